// File: rtl/rr_arbiter4_low_grant_if.sv
// Request/grant bundle for the four-way low-active round-robin arbiter.
interface rr_arbiter4_low_grant_if;
  logic       en_n;
  logic [3:0] req_n;
  logic [3:0] gnt_n;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output en_n, req_n,
    input  gnt_n, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  en_n, req_n,
    output gnt_n, gnt_id, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter4_low_grant.sv
// Four-requester round-robin arbiter with active-low requests/grants,
// a maximum hold time and a fixed dead gap between grants.
module rr_arbiter4_low_grant #(
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rr_arbiter4_low_grant_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state;
  logic [1:0] last;
  logic [7:0] hold_cnt;
  logic [3:0] gap_cnt;

  logic       pick_found;
  logic [1:0] pick_id;
  logic [1:0] idx;
  logic       hold_limit;
  logic       release_now;

  // Search last+1 .. last+4 (mod 4); the previous winner is tried last.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = last;
    idx        = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!pick_found && !bus.req_n[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  assign hold_limit  = (hold_cnt == 8'(MAX_HOLD));
  assign release_now = bus.req_n[bus.gnt_id] | bus.en_n | hold_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= 2'd3;
      hold_cnt      <= '0;
      gap_cnt       <= '0;
      bus.gnt_n     <= '1;
      bus.gnt_id    <= '0;
      bus.gnt_valid <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.en_n && pick_found) begin
            state         <= GRANT;
            bus.gnt_n     <= ~(4'b0001 << pick_id);
            bus.gnt_id    <= pick_id;
            bus.gnt_valid <= 1'b1;
            hold_cnt      <= 8'd1;
          end
        end
        GRANT: begin
          if (release_now) begin
            state         <= GAP;
            bus.gnt_n     <= '1;
            bus.gnt_valid <= 1'b0;
            last          <= bus.gnt_id;
            gap_cnt       <= 4'd1;
            bus.timeout   <= hold_limit && !bus.req_n[bus.gnt_id];
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES)) state <= IDLE;
          else                           gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter4_low_grant.sv
// Directed and randomized checks for rr_arbiter4_low_grant (MAX_HOLD=4, GAP_CYCLES=1).
module tb_rr_arbiter4_low_grant;

  localparam int unsigned MAX_HOLD   = 4;
  localparam int unsigned GAP_CYCLES = 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   run;

  rr_arbiter4_low_grant_if bus();

  rr_arbiter4_low_grant #(
    .MAX_HOLD   (MAX_HOLD),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] rr_order [4];
  logic [1:0] rr_id    [4];
  logic [3:0] one_req;
  logic [3:0] g;

  initial begin
    checks = 0;
    errors = 0;
    run    = 0;
    rr_order = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rr_id    = '{2'd1, 2'd2, 2'd3, 2'd0};
    rst_n = 1'b0;
    bus.en_n  = 1'b1;
    bus.req_n = 4'b1111;

    // 1: reset values, first grant, async reset mid-grant
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt_n", 8'(bus.gnt_n), 8'hF);
    chk("rst_gnt_id", 8'(bus.gnt_id), 8'h0);
    chk("rst_valid", 8'(bus.gnt_valid), 8'h0);
    chk("rst_timeout", 8'(bus.timeout), 8'h0);
    rst_n = 1'b1;
    bus.en_n  = 1'b0;
    bus.req_n = 4'b0000;
    step();
    chk("first_gnt_n", 8'(bus.gnt_n), 8'hE);
    chk("first_gnt_id", 8'(bus.gnt_id), 8'h0);
    chk("first_valid", 8'(bus.gnt_valid), 8'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_gnt_n", 8'(bus.gnt_n), 8'hF);
    chk("midrst_valid", 8'(bus.gnt_valid), 8'h0);
    chk("midrst_timeout", 8'(bus.timeout), 8'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("postrst_gnt_n", 8'(bus.gnt_n), 8'hE);
    chk("postrst_gnt_id", 8'(bus.gnt_id), 8'h0);

    // 2: round robin with all requesting; each grant drops its bit for one clk
    for (int k = 0; k < 4; k++) begin
      one_req = 4'b0001 << k;
      bus.req_n = one_req;
      step();
      chk("rr_gap1", 8'(bus.gnt_n), 8'hF);
      bus.req_n = 4'b0000;
      step();
      chk("rr_gap2", 8'(bus.gnt_n), 8'hF);
      step();
      chk("rr_gnt_n", 8'(bus.gnt_n), 8'(rr_order[k]));
      chk("rr_gnt_id", 8'(bus.gnt_id), 8'(rr_id[k]));
    end

    // 3: timeout on a lone requester, then re-grant after the gap
    bus.req_n = 4'b1111;
    step();
    chk("to_pre_rel", 8'(bus.gnt_n), 8'hF);
    chk("to_pre_timeout", 8'(bus.timeout), 8'h0);
    bus.req_n = 4'b1011;
    step();
    chk("to_pre_idle", 8'(bus.gnt_n), 8'hF);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("to_hold_gnt_n", 8'(bus.gnt_n), 8'hB);
      chk("to_hold_timeout", 8'(bus.timeout), 8'h0);
    end
    step();
    chk("to_rel_gnt_n", 8'(bus.gnt_n), 8'hF);
    chk("to_pulse", 8'(bus.timeout), 8'h1);
    chk("to_keep_id", 8'(bus.gnt_id), 8'h2);
    step();
    chk("to_pulse_end", 8'(bus.timeout), 8'h0);
    chk("to_gap", 8'(bus.gnt_n), 8'hF);
    step();
    chk("to_regrant", 8'(bus.gnt_n), 8'hB);
    chk("to_regrant_id", 8'(bus.gnt_id), 8'h2);

    // 4: forced release by enable, then disabled arbiter ignores requests
    bus.en_n = 1'b1;
    step();
    chk("en_rel_gnt_n", 8'(bus.gnt_n), 8'hF);
    chk("en_rel_timeout", 8'(bus.timeout), 8'h0);
    chk("en_rel_valid", 8'(bus.gnt_valid), 8'h0);
    bus.req_n = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("en_off_gnt_n", 8'(bus.gnt_n), 8'hF);
      chk("en_off_valid", 8'(bus.gnt_valid), 8'h0);
    end

    // 5: one-clock latency on grant and on release
    bus.en_n  = 1'b0;
    bus.req_n = 4'b1101;
    step();
    chk("lat_gnt_n", 8'(bus.gnt_n), 8'hD);
    chk("lat_gnt_id", 8'(bus.gnt_id), 8'h1);
    bus.req_n = 4'b1111;
    step();
    chk("lat_rel_gnt_n", 8'(bus.gnt_n), 8'hF);
    chk("lat_rel_id", 8'(bus.gnt_id), 8'h1);
    step();
    step();

    // 6: invariants over random stimulus
    for (int c = 0; c < 400; c++) begin
      bus.en_n  = ($urandom_range(0, 7) == 0);
      bus.req_n = 4'($urandom) & 4'($urandom);
      step();
      g = ~bus.gnt_n;
      chk("inv_onehot", 8'((g & (g - 4'd1)) == 4'd0), 8'h1);
      chk("inv_valid", 8'(bus.gnt_valid), 8'(bus.gnt_n != 4'b1111));
      if (bus.gnt_valid) run++;
      else run = 0;
      chk("inv_max_hold", 8'(run <= int'(MAX_HOLD)), 8'h1);
      if (bus.timeout) chk("inv_timeout_idle", 8'(bus.gnt_valid), 8'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
